interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_if.sv | 43 ++++
 rtl/interrupt_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/interrupt_controller_if.sv
// -----------------------------------------------------------------------------
// interrupt_controller_if
//   CPU data-memory bus as seen by the interrupt controller.
//
//   addr     : data-memory address from the CPU
//   w_data   : CPU store data
//   w_en     : CPU store strobe (one store per cycle with w_en=1)
//   ret_addr : CPU return address (pc+1, or the taken jump target)
//   r_data   : register read data, combinational from addr
//   sel      : high when addr falls in the controller window 0xFC..0xFF
//
//   Bus semantics: there is no valid/ready handshake. A store is accepted
//   on every posedge where w_en=1; reads are purely combinational.
//
//   master : the CPU side
//   slave  : the interrupt controller side
// -----------------------------------------------------------------------------
interface interrupt_controller_if;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       w_en;
    logic [7:0] ret_addr;
    logic [7:0] r_data;
    logic       sel;

    modport master (
        output addr,
        output w_data,
        output w_en,
        output ret_addr,
        input  r_data,
        input  sel
    );

    modport slave (
        input  addr,
        input  w_data,
        input  w_en,
        input  ret_addr,
        output r_data,
        output sel
    );
endinterface

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//   Four-source, rising-edge interrupt controller memory-mapped at 0xFC..0xFF.
//
//   Register map:
//     0xFC INT_STAT : [3:0] pending (write-1-to-clear), [5:4] serviced source
//                     index (read-only), [7:6] read as 0
//     0xFD INT_EN   : bit0 GIE, [4:1] per-source mask, [7:5] stored only
//     0xFE INT_VEC  : handler address, read/write
//     0xFF RET      : latched return address, read-only
//
//   Ports:
//     clock    : single clock, all state changes on posedge
//     reset_n  : asynchronous active-low reset
//     irq      : interrupt sources, synchronous, rising-edge sensitive
//     bus      : CPU data bus (slave modport)
//     int_req  : registered interrupt request, high for exactly one cycle
//     int_en   : INT_EN register contents
//     int_vec  : INT_VEC register contents
//
//   Sequencing: IDLE -> REQ (one cycle, int_req=1) -> SERVICE. On entry to
//   SERVICE the return address is captured and GIE is cleared. Software
//   returns by writing INT_EN with bit0=1, which also re-enables GIE.
// -----------------------------------------------------------------------------
module interrupt_controller (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [3:0]                  irq,
    interrupt_controller_if.slave       bus,
    output logic                        int_req,
    output logic [7:0]                  int_en,
    output logic [7:0]                  int_vec
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [7:0] ADDR_STAT = 8'hFC;
    localparam logic [7:0] ADDR_EN   = 8'hFD;
    localparam logic [7:0] ADDR_VEC  = 8'hFE;
    localparam logic [7:0] ADDR_RET  = 8'hFF;

    state_t     state_q, state_d;
    logic       int_req_q, int_req_d;
    logic [7:0] int_en_q, int_en_d;
    logic [7:0] int_vec_q, int_vec_d;
    logic [7:0] ret_q, ret_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] svc_idx_q, svc_idx_d;
    logic [3:0] irq_prev_q, irq_prev_d;

    logic       wr_stat;
    logic       wr_en_reg;
    logic       wr_vec;
    logic [3:0] irq_rise;
    logic [3:0] clr_mask;
    logic [3:0] eligible;
    logic [1:0] pick_idx;

    // Register-select decode
    assign bus.sel   = (bus.addr[7:2] == 6'b111111);
    assign wr_stat   = bus.w_en && (bus.addr == ADDR_STAT);
    assign wr_en_reg = bus.w_en && (bus.addr == ADDR_EN);
    assign wr_vec    = bus.w_en && (bus.addr == ADDR_VEC);

    assign irq_rise  = irq & ~irq_prev_q;
    assign clr_mask  = wr_stat ? bus.w_data[3:0] : 4'h0;
    assign eligible  = pending_q & int_en_q[4:1];

    // Fixed priority, lowest index wins
    always_comb begin
        pick_idx = 2'd0;
        if (eligible[0])      pick_idx = 2'd0;
        else if (eligible[1]) pick_idx = 2'd1;
        else if (eligible[2]) pick_idx = 2'd2;
        else if (eligible[3]) pick_idx = 2'd3;
    end

    always_comb begin
        state_d    = state_q;
        svc_idx_d  = svc_idx_q;
        ret_d      = ret_q;
        int_en_d   = int_en_q;
        int_vec_d  = int_vec_q;
        irq_prev_d = irq;
        // OR-ing the new edges in after the clear makes a coincident set win
        pending_d  = (pending_q & ~clr_mask) | irq_rise;

        if (wr_en_reg) int_en_d  = bus.w_data;
        if (wr_vec)    int_vec_d = bus.w_data;

        case (state_q)
            ST_IDLE: begin
                if ((eligible != 4'h0) && int_en_q[0]) begin
                    state_d   = ST_REQ;
                    svc_idx_d = pick_idx;
                end
            end
            ST_REQ: begin
                state_d     = ST_SERVICE;
                ret_d       = bus.ret_addr;
                // GIE clear overrides a coincident software write to bit0
                int_en_d[0] = 1'b0;
            end
            ST_SERVICE: begin
                if (wr_en_reg && bus.w_data[0]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        int_req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            int_req_q  <= 1'b0;
            int_en_q   <= 8'h00;
            int_vec_q  <= 8'h00;
            ret_q      <= 8'h00;
            pending_q  <= 4'h0;
            svc_idx_q  <= 2'd0;
            irq_prev_q <= 4'h0;
        end else begin
            state_q    <= state_d;
            int_req_q  <= int_req_d;
            int_en_q   <= int_en_d;
            int_vec_q  <= int_vec_d;
            ret_q      <= ret_d;
            pending_q  <= pending_d;
            svc_idx_q  <= svc_idx_d;
            irq_prev_q <= irq_prev_d;
        end
    end

    always_comb begin
        bus.r_data = 8'h00;
        case (bus.addr)
            ADDR_STAT: bus.r_data = {2'b00, svc_idx_q, pending_q};
            ADDR_EN:   bus.r_data = int_en_q;
            ADDR_VEC:  bus.r_data = int_vec_q;
            ADDR_RET:  bus.r_data = ret_q;
            default:   bus.r_data = 8'h00;
        endcase
    end

    assign int_req = int_req_q;
    assign int_en  = int_en_q;
    assign int_vec = int_vec_q;

endmodule
